// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse decoder: FSM state encoding,
// protocol byte constants and the default cursor range.
package ps2_pkg;

    // Decoder FSM: enable handshake (SEND..WAIT_ACK) then packet byte slots.
    typedef enum logic [2:0] {
        SEND      = 3'd0,
        WAIT_SENT = 3'd1,
        WAIT_ACK  = 3'd2,
        B0        = 3'd3,
        B1        = 3'd4,
        B2        = 3'd5
    } ps2_state_t;

    // "Enable data reporting" command and the device acknowledge byte.
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;

    // Default cursor limits (320x200 screen).
    localparam int unsigned X_MAX_DEFAULT = 319;
    localparam int unsigned Y_MAX_DEFAULT = 199;

endpackage

// File: rtl/ps2_mouse.sv
// PS/2 mouse packet decoder.
// Sends the F4 enable command, waits for the FA acknowledge, then decodes
// 3-byte movement packets into a clamped cursor position and button state.
// Ports:
//   clock, reset_n        : 50 MHz clock, asynchronous active-low reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   cmd_data, cmd_send    : command byte and held request to the controller
//   cmd_sent, cmd_timeout : controller completion / failure pulses
//   mouse_x, mouse_y      : cursor position (0..X_MAX, 0..Y_MAX, Y grows down)
//   mouse_cmd             : buttons {right, left}, 1 = pressed
module ps2_mouse
    import ps2_pkg::*;
#(
    parameter int unsigned X_MAX = X_MAX_DEFAULT,
    parameter int unsigned Y_MAX = Y_MAX_DEFAULT,
    parameter int unsigned TMO   = 1_000_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] cmd_data,
    output logic       cmd_send,
    input  logic       cmd_sent,
    input  logic       cmd_timeout,
    output logic [8:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic [1:0] mouse_cmd
);

    localparam int unsigned CW = (TMO < 1) ? 1 : $clog2(TMO + 1);

    localparam logic signed [10:0] X_HI = $signed(11'(X_MAX));
    localparam logic signed [10:0] Y_HI = $signed(11'(Y_MAX));

    // Saturate a signed intermediate position into 0..hi.
    function automatic logic signed [10:0] clamp11(input logic signed [10:0] v,
                                                   input logic signed [10:0] hi);
        logic signed [10:0] r;
        r = v;
        if (v < 11'sd0) begin
            r = 11'sd0;
        end else if (v > hi) begin
            r = hi;
        end
        return r;
    endfunction

    ps2_state_t state, state_nxt;

    logic [CW-1:0] gap_cnt, gap_nxt;
    logic          gap_hit;

    // Header byte fields kept for the commit: {y_ovf, x_ovf, y_sign, x_sign}
    // and {right, left}. The always-one bit is only used for sync.
    logic [3:0] b0_hi_q,  b0_hi_nxt;
    logic [1:0] b0_btn_q, b0_btn_nxt;
    logic [7:0] b1_q,     b1_nxt;

    logic [7:0] cmd_data_nxt;
    logic       cmd_send_nxt;
    logic [8:0] mouse_x_nxt;
    logic [7:0] mouse_y_nxt;
    logic [1:0] mouse_cmd_nxt;

    logic [8:0]        dx, dy;
    logic signed [10:0] x_calc, y_calc;

    // Idle-cycle gap has exceeded the limit once the counter sits at TMO.
    assign gap_hit = (gap_cnt == CW'(TMO));

    // Nine-bit deltas; dy uses the byte arriving now, since commit is on byte 2.
    assign dx = {b0_hi_q[0], b1_q};
    assign dy = {b0_hi_q[1], rx_data};

    // Eleven bits hold 0..511 +/- 256 without wrap.
    assign x_calc = $signed({2'b00, mouse_x}) + $signed({{2{dx[8]}}, dx});
    assign y_calc = $signed({3'b000, mouse_y}) - $signed({{2{dy[8]}}, dy});

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SEND;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            SEND: begin
                state_nxt = WAIT_SENT;
            end
            WAIT_SENT: begin
                // A failed transmission takes priority over a completion.
                if (cmd_timeout) begin
                    state_nxt = SEND;
                end else if (cmd_sent) begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (rx_valid) begin
                    state_nxt = (rx_data == RSP_ACK) ? B0 : SEND;
                end else if (gap_hit) begin
                    state_nxt = SEND;
                end
            end
            B0: begin
                // Bit 3 of a header byte is always set; anything else is resync junk.
                if (rx_valid && rx_data[3]) begin
                    state_nxt = B1;
                end
            end
            B1: begin
                if (rx_valid) begin
                    state_nxt = B2;
                end else if (gap_hit) begin
                    state_nxt = B0;
                end
            end
            B2: begin
                if (rx_valid || gap_hit) begin
                    state_nxt = B0;
                end
            end
            default: begin
                state_nxt = SEND;
            end
        endcase
    end

    // Next values of the registered outputs, packet fields and gap counter.
    always_comb begin
        cmd_data_nxt  = cmd_data;
        cmd_send_nxt  = cmd_send;
        mouse_x_nxt   = mouse_x;
        mouse_y_nxt   = mouse_y;
        mouse_cmd_nxt = mouse_cmd;
        b0_hi_nxt     = b0_hi_q;
        b0_btn_nxt    = b0_btn_q;
        b1_nxt        = b1_q;

        // Restart on every byte and on every state change; saturate otherwise.
        if (rx_valid || (state_nxt != state)) begin
            gap_nxt = '0;
        end else if (!gap_hit) begin
            gap_nxt = gap_cnt + CW'(1);
        end else begin
            gap_nxt = gap_cnt;
        end

        case (state)
            SEND: begin
                cmd_data_nxt = CMD_ENABLE;
                cmd_send_nxt = 1'b1;
            end
            WAIT_SENT: begin
                if (cmd_timeout || cmd_sent) begin
                    cmd_send_nxt = 1'b0;
                end
            end
            B0: begin
                if (rx_valid && rx_data[3]) begin
                    b0_hi_nxt  = rx_data[7:4];
                    b0_btn_nxt = rx_data[1:0];
                end
            end
            B1: begin
                if (rx_valid) begin
                    b1_nxt = rx_data;
                end
            end
            B2: begin
                // Commit: buttons always, movement only without overflow.
                if (rx_valid) begin
                    mouse_cmd_nxt = b0_btn_q;
                    if (!(b0_hi_q[2] || b0_hi_q[3])) begin
                        mouse_x_nxt = 9'(clamp11(x_calc, X_HI));
                        mouse_y_nxt = 8'(clamp11(y_calc, Y_HI));
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt   <= '0;
            b0_hi_q   <= '0;
            b0_btn_q  <= '0;
            b1_q      <= '0;
            cmd_data  <= 8'h00;
            cmd_send  <= 1'b0;
            mouse_x   <= '0;
            mouse_y   <= '0;
            mouse_cmd <= '0;
        end else begin
            gap_cnt   <= gap_nxt;
            b0_hi_q   <= b0_hi_nxt;
            b0_btn_q  <= b0_btn_nxt;
            b1_q      <= b1_nxt;
            cmd_data  <= cmd_data_nxt;
            cmd_send  <= cmd_send_nxt;
            mouse_x   <= mouse_x_nxt;
            mouse_y   <= mouse_y_nxt;
            mouse_cmd <= mouse_cmd_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_mouse.sv
// Self-checking bench for ps2_mouse: directed handshake/packet cases with
// literal expectations plus randomized packet streams checked every cycle
// against a byte-level behavioural model.
module tb_ps2_mouse;

    localparam int unsigned TMO = 40;
    localparam int XM = 319;
    localparam int YM = 199;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       cmd_sent = 1'b0;
    logic       cmd_timeout = 1'b0;
    logic [7:0] cmd_data;
    logic       cmd_send;
    logic [8:0] mouse_x;
    logic [7:0] mouse_y;
    logic [1:0] mouse_cmd;

    ps2_mouse #(.X_MAX(319), .Y_MAX(199), .TMO(TMO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_data   (cmd_data),
        .cmd_send   (cmd_send),
        .cmd_sent   (cmd_sent),
        .cmd_timeout(cmd_timeout),
        .mouse_x    (mouse_x),
        .mouse_y    (mouse_y),
        .mouse_cmd  (mouse_cmd)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model: cursor, buttons and packet assembly position.
    int         exp_x = 0;
    int         exp_y = 0;
    int         exp_cmd = 0;
    int         phase = 0;
    logic [7:0] p0 = 8'h00;
    logic [7:0] p1 = 8'h00;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        exp_x = 0; exp_y = 0; exp_cmd = 0; phase = 0;
    endtask

    // Apply one received byte, preceded by 'idle' strobe-free cycles.
    task automatic model_byte(input logic [7:0] b, input int idle);
        int dx, dy;
        if (phase != 0 && idle > int'(TMO)) phase = 0;
        case (phase)
            0: if (b[3]) begin p0 = b; phase = 1; end
            1: begin p1 = b; phase = 2; end
            default: begin
                phase = 0;
                exp_cmd = int'(p0[1:0]);
                if (!p0[6] && !p0[7]) begin
                    dx = int'(p1) - (p0[4] ? 256 : 0);
                    dy = int'(b)  - (p0[5] ? 256 : 0);
                    exp_x = clampi(exp_x + dx, 0, XM);
                    exp_y = clampi(exp_y - dy, 0, YM);
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        tick();
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idle);
        repeat (idle) tick();
        rx_data = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        model_byte(b, idle);
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 0);
        send_byte(b, 0);
        send_byte(c, 0);
    endtask

    task automatic pulse_sent();
        tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
    endtask

    // Bounded wait for the command request, then verify its byte.
    task automatic wait_cmd_send(input string name, input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clock);
            if (cmd_send) seen = 1'b1;
        end
        check(name, int'(seen), 1);
        if (seen) check({name, "_data"}, int'(cmd_data), 'hF4);
    endtask

    task automatic check_out(input string name, input int x, input int y, input int btn);
        check({name, "_x"}, int'(mouse_x), x);
        check({name, "_y"}, int'(mouse_y), y);
        check({name, "_btn"}, int'(mouse_cmd), btn);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clock);
                if (check_en) begin
                    checks++;
                    if (int'(mouse_x) != exp_x || int'(mouse_y) != exp_y ||
                        int'(mouse_cmd) != exp_cmd) begin
                        failures++;
                        if (failures <= 20)
                            $display("FAIL model_cmp t=%0t actual x=%0d y=%0d btn=%0d required x=%0d y=%0d btn=%0d",
                                     $time, mouse_x, mouse_y, mouse_cmd, exp_x, exp_y, exp_cmd);
                    end
                end
            end
        join_none

        // Reset values.
        repeat (3) @(negedge clock);
        check("rst_cmd_send", int'(cmd_send), 0);
        check("rst_cmd_data", int'(cmd_data), 0);
        check_out("rst", 0, 0, 0);

        // First edge after release issues F4.
        reset_n = 1'b1;
        @(negedge clock);
        check("release_cmd_send", int'(cmd_send), 1);
        check("release_cmd_data", int'(cmd_data), 'hF4);

        // Simultaneous timeout and sent: timeout wins, F4 is resent.
        tick();
        cmd_timeout = 1'b1;
        cmd_sent = 1'b1;
        tick();
        cmd_timeout = 1'b0;
        cmd_sent = 1'b0;
        check("tmo_drop_send", int'(cmd_send), 0);
        wait_cmd_send("resend_after_cmd_tmo", 4);

        // Ack while still in WAIT_SENT is ignored; no ack afterwards -> resend.
        rx_pulse(8'hFA);
        pulse_sent();
        check("sent_drop_send", int'(cmd_send), 0);
        repeat (TMO) tick();
        check("no_early_resend", int'(cmd_send), 0);
        wait_cmd_send("resend_after_ack_tmo", 8);

        // Wrong acknowledge byte -> resend.
        pulse_sent();
        rx_pulse(8'hAA);
        wait_cmd_send("resend_after_bad_ack", 4);

        // Successful handshake; model checking from here on.
        pulse_sent();
        rx_pulse(8'hFA);
        model_reset();
        check_en = 1'b1;
        check_out("after_ack", 0, 0, 0);

        // Directed packets with hand-computed results.
        send3(8'h29, 8'h05, 8'hFB);
        check_out("pkt_5_5", 5, 5, 1);
        send3(8'h08, 8'hFF, 8'h00);
        send3(8'h08, 8'h3A, 8'h03);
        check_out("pkt_318_2", 318, 2, 0);
        send3(8'h0A, 8'h0A, 8'h00);
        check_out("clamp_xmax", 319, 2, 2);
        send3(8'h28, 8'h00, 8'hFC);
        check_out("neg_dy", 319, 6, 0);
        send3(8'h08, 8'h00, 8'h7F);
        check_out("clamp_y0", 319, 0, 0);
        send3(8'h0A, 8'h00, 8'h00);
        send3(8'h48, 8'h7F, 8'h00);
        check_out("x_ovf", 319, 0, 0);
        send_byte(8'h00, 0);
        send3(8'h19, 8'hFB, 8'h00);
        check_out("after_stray", 314, 0, 1);
        send_byte(8'h09, 0);
        send_byte(8'h08, TMO + 1);
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        check_out("gap_drop", 317, 0, 0);
        send_byte(8'h08, 0);
        send_byte(8'h02, TMO);
        send_byte(8'h00, TMO);
        check_out("gap_edge_ok", 319, 0, 0);

        // Randomized packet stream.
        for (int n = 0; n < 150; n++) begin
            logic [7:0] b0, b1, b2;
            b0 = 8'($urandom);
            if ($urandom_range(0, 6) != 0) b0[3] = 1'b1;
            if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            send_byte(b0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 2)) : int'($urandom_range(0, 3)));
            send_byte(b1, ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 2)) : int'($urandom_range(0, 3)));
            send_byte(b2, ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 2)) : int'($urandom_range(0, 3)));
        end
        // Flush any partial packet so the directed part starts aligned.
        repeat (TMO + 3) tick();
        phase = 0;

        // Reset in the middle of a packet aborts it and restarts the handshake.
        send3(8'h29, 8'h10, 8'hF0);
        send_byte(8'h08, 0);
        send_byte(8'h05, 0);
        tick();
        reset_n = 1'b0;
        model_reset();
        @(negedge clock);
        check("midrst_cmd_send", int'(cmd_send), 0);
        check_out("midrst", 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_resend", int'(cmd_send), 1);
        check("midrst_resend_data", int'(cmd_data), 'hF4);
        pulse_sent();
        rx_pulse(8'hFA);
        send3(8'h29, 8'h03, 8'hFD);
        check_out("post_rst_pkt", 3, 3, 1);

        repeat (3) tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
